// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and data-memory signal bundle around the arbiter
interface dmem_arbiter_if #(parameter int ADDR_W = 10);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic              cpu_stall_o;
  logic              cpu_rvalid_o;
  logic [31:0]       cpu_rdata_o;
  logic              dma_req_i;
  logic              dma_we_i;
  logic [31:0]       dma_addr_i;
  logic [31:0]       dma_wdata_i;
  logic              dma_gnt_o;
  logic              dma_rvalid_o;
  logic [31:0]       dma_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_stall_o, cpu_rvalid_o, cpu_rdata_o,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_stall_o, cpu_rvalid_o, cpu_rdata_o,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for a single-port synchronous-read data memory
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_e;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       idle, dma_win, cpu_win, cpu_rd, dma_rd;
  logic       unused_addr;
  // Issue is gated by reset so every memory/grant output sits at zero while rst_i is low
  assign idle    = rst_i && state_q == IDLE;
  assign dma_win = idle && bus.dma_req_i && (cnt_q == LIM || !bus.cpu_req_i);
  assign cpu_win = idle && bus.cpu_req_i && !dma_win;
  assign cpu_rd  = state_q == CPU_RD;
  assign dma_rd  = state_q == DMA_RD;
  always_comb begin
    state_d = dma_win ? (bus.dma_we_i ? IDLE : DMA_RD)
            : cpu_win ? (bus.cpu_we_i ? IDLE : CPU_RD)
            : IDLE;
    cnt_d   = (dma_win || !bus.dma_req_i) ? 4'd0
            : (cpu_win && cnt_q != LIM) ? cnt_q + 4'd1
            : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.mem_en_o     = dma_win || cpu_win;
  assign bus.mem_we_o     = dma_win ? bus.dma_we_i : (cpu_win && bus.cpu_we_i);
  assign bus.mem_addr_o   = dma_win ? bus.dma_addr_i[ADDR_W+1:2]
                          : cpu_win ? bus.cpu_addr_i[ADDR_W+1:2]
                          : '0;
  assign bus.mem_wdata_o  = dma_win ? bus.dma_wdata_i : cpu_win ? bus.cpu_wdata_i : 32'd0;
  assign bus.dma_gnt_o    = dma_win;
  assign bus.cpu_stall_o  = bus.cpu_req_i && !((cpu_win && bus.cpu_we_i) || cpu_rd);
  assign bus.cpu_rvalid_o = cpu_rd;
  assign bus.dma_rvalid_o = dma_rd;
  assign bus.cpu_rdata_o  = cpu_rd ? bus.mem_rdata_i : 32'd0;
  assign bus.dma_rdata_o  = dma_rd ? bus.mem_rdata_i : 32'd0;
  assign unused_addr = ^{bus.cpu_addr_i[1:0], bus.cpu_addr_i[31:ADDR_W+2],
                         bus.dma_addr_i[1:0], bus.dma_addr_i[31:ADDR_W+2]};
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioral memory
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  logic [31:0] mem [0:1023];
  always #5 clk = ~clk;
  dmem_arbiter_if #(.ADDR_W(10)) bus ();
  dmem_arbiter #(.ADDR_W(10), .STARVE_LIMIT(4)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus.slave));
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pop_cpu(output logic [31:0] v);
    v = cpu_q.size() > 0 ? cpu_q.pop_front() : 32'hxxxx_xxxx;
  endtask
  task automatic pop_dma(output logic [31:0] v);
    v = dma_q.size() > 0 ? dma_q.pop_front() : 32'hxxxx_xxxx;
  endtask
  task automatic cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req_i = req; bus.cpu_we_i = we; bus.cpu_addr_i = a; bus.cpu_wdata_i = d;
  endtask
  task automatic dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dma_req_i = req; bus.dma_we_i = we; bus.dma_addr_i = a; bus.dma_wdata_i = d;
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic quiet(input string tag);
    chk({tag, "_en"}, 32'(bus.mem_en_o), 0);
    chk({tag, "_gnt"}, 32'(bus.dma_gnt_o), 0);
    chk({tag, "_crv"}, 32'(bus.cpu_rvalid_o), 0);
    chk({tag, "_drv"}, 32'(bus.dma_rvalid_o), 0);
  endtask
  initial begin
    logic [31:0] e;
    bus.mem_rdata_i = 32'd0;
    cpu(1'b1, 1'b0, 32'h0, 32'h0);
    dma(1'b0, 1'b0, 32'h0, 32'h0);
    // Reset state: requests are ignored, stall follows cpu_req
    #1;
    chk("rst_stall", 32'(bus.cpu_stall_o), 1);
    quiet("rst");
    chk("rst_addr", 32'(bus.mem_addr_o), 0);
    step(); step();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    // CPU store 0xDEADBEEF to 0x40: no stall
    step();
    cpu(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF); #1;
    chk("st_stall", 32'(bus.cpu_stall_o), 0);
    chk("st_en", 32'(bus.mem_en_o), 1);
    chk("st_we", 32'(bus.mem_we_o), 1);
    chk("st_addr", 32'(bus.mem_addr_o), 32'h10);
    chk("st_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    // CPU load from 0x40: one stall cycle, data the cycle after
    step();
    cpu(1'b1, 1'b0, 32'h40, 32'h0); #1;
    cpu_q.push_back(32'hDEAD_BEEF);
    chk("ld_stall", 32'(bus.cpu_stall_o), 1);
    chk("ld_we", 32'(bus.mem_we_o), 0);
    chk("ld_addr", 32'(bus.mem_addr_o), 32'h10);
    chk("ld_crv0", 32'(bus.cpu_rvalid_o), 0);
    chk("ld_crd0", bus.cpu_rdata_o, 0);
    step(); #1;
    pop_cpu(e);
    chk("ld_stall2", 32'(bus.cpu_stall_o), 0);
    chk("ld_en2", 32'(bus.mem_en_o), 0);
    chk("ld_crv", 32'(bus.cpu_rvalid_o), 1);
    chk("ld_crd", bus.cpu_rdata_o, e);
    chk("ld_drv", 32'(bus.dma_rvalid_o), 0);
    // DMA alone: write then read back 0x80
    step();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    dma(1'b1, 1'b1, 32'h80, 32'h1234_5678); #1;
    chk("dw_gnt", 32'(bus.dma_gnt_o), 1);
    chk("dw_we", 32'(bus.mem_we_o), 1);
    chk("dw_addr", 32'(bus.mem_addr_o), 32'h20);
    chk("dw_wdata", bus.mem_wdata_o, 32'h1234_5678);
    step();
    dma(1'b1, 1'b0, 32'h80, 32'h0); #1;
    dma_q.push_back(32'h1234_5678);
    chk("dr_gnt", 32'(bus.dma_gnt_o), 1);
    chk("dr_we", 32'(bus.mem_we_o), 0);
    step();
    dma(1'b0, 1'b0, 32'h0, 32'h0); #1;
    pop_dma(e);
    chk("dr_drv", 32'(bus.dma_rvalid_o), 1);
    chk("dr_drd", bus.dma_rdata_o, e);
    chk("dr_crv", 32'(bus.cpu_rvalid_o), 0);
    chk("dr_crd", bus.cpu_rdata_o, 0);
    chk("dr_en", 32'(bus.mem_en_o), 0);
    // Contention: CPU writes every cycle, DMA write pending; DMA forced at cycle 4
    for (int i = 0; i < 4; i++) begin
      step();
      cpu(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      dma(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D); #1;
      chk($sformatf("ct%0d_stall", i), 32'(bus.cpu_stall_o), 0);
      chk($sformatf("ct%0d_gnt", i), 32'(bus.dma_gnt_o), 0);
      chk($sformatf("ct%0d_addr", i), 32'(bus.mem_addr_o), 32'h80 + 32'(i));
    end
    step();
    cpu(1'b1, 1'b1, 32'h210, 32'hA000_0004); #1;
    chk("ct4_gnt", 32'(bus.dma_gnt_o), 1);
    chk("ct4_stall", 32'(bus.cpu_stall_o), 1);
    chk("ct4_addr", 32'(bus.mem_addr_o), 32'h40);
    chk("ct4_wdata", bus.mem_wdata_o, 32'hCAFE_F00D);
    step();
    dma(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("ct5_stall", 32'(bus.cpu_stall_o), 0);
    chk("ct5_gnt", 32'(bus.dma_gnt_o), 0);
    chk("ct5_addr", 32'(bus.mem_addr_o), 32'h84);
    // Starve the DMA read request so it wins while the CPU asks for a read
    for (int i = 0; i < 4; i++) begin
      step();
      cpu(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'h0);
      dma(1'b1, 1'b0, 32'h80, 32'h0); #1;
      chk($sformatf("bk%0d_gnt", i), 32'(bus.dma_gnt_o), 0);
    end
    step();
    cpu(1'b1, 1'b0, 32'h40, 32'h0); #1;
    dma_q.push_back(32'h1234_5678);
    chk("bk_c0_gnt", 32'(bus.dma_gnt_o), 1);
    chk("bk_c0_stall", 32'(bus.cpu_stall_o), 1);
    step();
    dma(1'b0, 1'b0, 32'h0, 32'h0); #1;
    pop_dma(e);
    chk("bk_c1_stall", 32'(bus.cpu_stall_o), 1);
    chk("bk_c1_drv", 32'(bus.dma_rvalid_o), 1);
    chk("bk_c1_drd", bus.dma_rdata_o, e);
    chk("bk_c1_en", 32'(bus.mem_en_o), 0);
    step(); #1;
    cpu_q.push_back(32'hDEAD_BEEF);
    chk("bk_c2_stall", 32'(bus.cpu_stall_o), 1);
    chk("bk_c2_en", 32'(bus.mem_en_o), 1);
    chk("bk_c2_addr", 32'(bus.mem_addr_o), 32'h10);
    step(); #1;
    pop_cpu(e);
    chk("bk_c3_stall", 32'(bus.cpu_stall_o), 0);
    chk("bk_c3_crv", 32'(bus.cpu_rvalid_o), 1);
    chk("bk_c3_crd", bus.cpu_rdata_o, e);
    // Idle for 10 cycles
    step();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      quiet($sformatf("idle%0d", i));
      step();
    end
    // Counter must be clear after idle: simultaneous requests go to CPU
    cpu(1'b1, 1'b1, 32'h3F0, 32'h1);
    dma(1'b1, 1'b1, 32'h3F4, 32'h2); #1;
    chk("post_idle_gnt", 32'(bus.dma_gnt_o), 0);
    chk("post_idle_addr", 32'(bus.mem_addr_o), 32'hFC);
    step();
    dma(1'b0, 1'b0, 32'h0, 32'h0);
    // Reset in the middle of a CPU read
    cpu(1'b1, 1'b0, 32'h10, 32'h0); #1;
    chk("mr_en", 32'(bus.mem_en_o), 1);
    chk("mr_addr", 32'(bus.mem_addr_o), 32'h4);
    #2 rst_n = 1'b0; #1;
    chk("mr_rst_stall", 32'(bus.cpu_stall_o), 1);
    chk("mr_rst_addr", 32'(bus.mem_addr_o), 0);
    quiet("mr_rst");
    step(); #1;
    quiet("mr_next");
    chk("mr_next_crd", bus.cpu_rdata_o, 0);
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    step(); #1;
    quiet("mr_rel");
    chk("mr_rel_stall", 32'(bus.cpu_stall_o), 0);
    chk("sb_empty", 32'(cpu_q.size() + dma_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
